uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Transmit-side output path for the CPU core. It accepts single-byte writes from the core's output instruction into a FIFO and drains them in order through an internal `uart_tx` instance onto `txd`, so the core does not stall on every byte. It is the counterpart of the receive path that feeds bytes into the core.

## Interface
- `CLK_PER_HALF_BIT`, 5208: passed unchanged to the internal `uart_tx`; one serial bit lasts 2*CLK_PER_HALF_BIT cycles.
- `DEPTH_LOG2`, 4: FIFO depth = 2**DEPTH_LOG2 bytes; legal range 1..8.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `wdata`  in  8  byte to enqueue.
- `we`  in  1  enqueue strobe, one byte per cycle high.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- `idle`  out  1  `empty` and FSM in IDLE and `uart_tx` not busy; flush-complete indication.
- `ovf`  out  1  sticky overflow flag (see Configuration).
- `txd`  out  1  serial line, idle high.

## Operation
- FIFO: circular buffer of DEPTH bytes, read/write pointers DEPTH_LOG2 bits wide, wrapping modulo DEPTH; `count` is held as a separate register.
- Enqueue: the write is accepted iff `we && !full` in that cycle. `full` is the registered value at the start of the cycle. A pop in the same cycle does not make room for a write while `full` is high.
- A write while full is dropped. FIFO contents and pointers are unchanged.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- Drain FSM, with the internal `tx_start` driven as a register:
  - IDLE: if `!empty && !tx_busy`, pop the head byte into the `uart_tx` data register, set `tx_start`=1 and go to START.
  - START: clear `tx_start` and go to SETTLE. `tx_start` is high for exactly one cycle.
  - SETTLE: one dead cycle so that `tx_busy` reflects the accepted frame, then go to WAIT.
  - WAIT: stay while `tx_busy`; go to IDLE when `!tx_busy`.
- Bytes leave in write order. Each frame is 1 start bit, 8 data bits LSB first, and 1 stop bit.
- Reset values: `count`=0, `empty`=1, `full`=0, `idle`=1, `ovf`=0, `txd`=1, FSM=IDLE, `tx_start`=0, pointers=0.
- Reset mid-frame: the frame is aborted, `txd` returns high the cycle after reset is sampled, and queued bytes are discarded.

## Timing
- Write latency: a byte accepted at edge N shows in `count`/`empty` after edge N.
- Start latency: with FSM in IDLE and `uart_tx` not busy, a byte written at edge N is popped and `tx_start` rises at edge N+1. `count` decrements at that same edge.
- Frame duration: 20*CLK_PER_HALF_BIT cycles. Back-to-back bytes add at most 3 cycles of idle-high between the stop bit and the next start bit.
- `full`, `empty` and `count` are all registered and consistent in every cycle.
- `idle` is combinational from registered state. It is high at least one cycle after the stop bit of the last byte completes.

## Configuration
- `UART_TX_BUF_OVF_EN` defined:
  - `ovf` is set at the edge where `we && full`.
  - It stays 1 until reset and is unaffected by later writes or drains.
- `UART_TX_BUF_OVF_EN` undefined:
  - `ovf` is constant 0 and no flag register is synthesized.
  - Dropped writes are still dropped silently.

## Test plan
- Single byte: reset, then write 0x55 once. `tx_start` pulses one cycle. The `txd` frame is 0,1,0,1,0,1,0,1,0,1, each bit 2*CLK_PER_HALF_BIT cycles (use CLK_PER_HALF_BIT=4). `idle` returns to 1 afterwards.
- Ordering: write 0x01, 0x02, 0x03 on consecutive cycles. The bench UART decoder receives 0x01, 0x02, 0x03 in order. `count` peaks at 3 (or 2 if the first pop overlaps) and reaches 0.
- Full/overflow: DEPTH_LOG2=2, `uart_tx` busy, write 6 bytes 0xA0..0xA5.
  - `full`=1 after the 4th write (or 5th if one byte was already popped).
  - Extra bytes are dropped and `ovf`=1 with the macro, 0 without.
  - The decoder receives only the accepted bytes.
- Wrap-around: DEPTH_LOG2=2, stream 10 bytes 0x10..0x19 pacing writes on `!full`. All 10 bytes arrive intact and in order across pointer wrap.
- Simultaneous write/pop: write a byte in the exact cycle the FSM pops with `count`=2. `count` stays 2 and the byte order is preserved.
- Reset mid-frame: assert `rstn`=0 during data bit 3 of 0xFF with 2 bytes queued. `txd`=1 the cycle after reset, `count`=0, `ovf`=0, and no further frames occur.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// ============================================================================
// uart_tx_buffer : byte FIFO drained in write order through an internal uart_tx.
// Optional macro UART_TX_BUF_OVF_EN enables the sticky overflow flag on ovf.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_buffer #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            wdata,
  input  logic                  we,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  idle,
  output logic                  ovf,
  output logic                  txd
);

  localparam int                    c_depth_int = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_depth     = (DEPTH_LOG2+1)'(c_depth_int);
  localparam logic [DEPTH_LOG2:0]   c_cnt_one   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one   = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t                r_state;
  logic [7:0]            r_mem [c_depth_int];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_tx_start;
  logic [7:0]            r_tx_data;
  logic                  w_tx_busy;
  logic                  w_wr;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_count_nxt;

  // A pop never frees a slot for a same-cycle write: acceptance uses registered full.
  assign w_wr  = we && !r_full;
  assign w_pop = (r_state == S_IDLE) && !r_empty && !w_tx_busy;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // SETTLE gives uart_tx one cycle to raise busy before WAIT samples it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          r_tx_start <= 1'b0;
          r_state    <= S_SETTLE;
        end
        S_SETTLE: begin
          r_state <= S_WAIT;
        end
        default: begin
          if (!w_tx_busy) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef UART_TX_BUF_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (we && r_full) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;
  assign idle  = r_empty && (r_state == S_IDLE) && !w_tx_busy;

  uart_tx #(
    .CLK_PER_HALF_BIT (CLK_PER_HALF_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .rstn  (rstn),
    .start (r_tx_start),
    .data  (r_tx_data),
    .txd   (txd),
    .busy  (w_tx_busy)
  );

endmodule

// Serialiser: 1 start bit, 8 data bits LSB first, 1 stop bit.
module uart_tx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy
);

  localparam int                 c_bit_cycles = 2 * CLK_PER_HALF_BIT;
  localparam int                 c_cnt_w      = (c_bit_cycles > 2) ? $clog2(c_bit_cycles) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(c_bit_cycles - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [3:0]         r_bit_cnt;
  logic [8:0]         r_shift;
  logic               r_txd;
  logic               r_busy;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '1;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else if (!r_busy) begin
      r_txd <= 1'b1;
      if (start) begin
        r_shift   <= {1'b1, data};
        r_txd     <= 1'b0;
        r_busy    <= 1'b1;
        r_clk_cnt <= '0;
        r_bit_cnt <= '0;
      end
    end else if (r_clk_cnt == c_cnt_last) begin
      r_clk_cnt <= '0;
      if (r_bit_cnt == 4'd9) begin
        r_busy <= 1'b0;
        r_txd  <= 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_txd     <= r_shift[0];
        r_shift   <= {1'b1, r_shift[8:1]};
      end
    end else begin
      r_clk_cnt <= r_clk_cnt + c_cnt_one;
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
// ============================================================================
// tb_uart_tx_buffer : scoreboard bench with a serial-line decoder for uart_tx_buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_buffer;

  localparam int H     = 4;
  localparam int BITC  = 2 * H;
  localparam int FRAME = 20 * H;
`ifdef UART_TX_BUF_OVF_EN
  localparam logic c_ovf_exp = 1'b1;
`else
  localparam logic c_ovf_exp = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       we    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       idle;
  logic       ovf;
  logic       txd;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  int         rx_starts = 0;
  int         pulses    = 0;

  uart_tx_buffer #(
    .CLK_PER_HALF_BIT (H),
    .DEPTH_LOG2       (2)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .wdata (wdata),
    .we    (we),
    .full  (full),
    .empty (empty),
    .count (count),
    .idle  (idle),
    .ovf   (ovf),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rstn && dut.r_tx_start) pulses++;

  // Line decoder: samples mid-bit, skips frames cut short by reset.
  logic       prev_txd = 1'b1;
  logic [7:0] rx_b;
  logic       rx_ab;
  logic       rx_st;
  logic       rx_sp;
  always begin
    @(negedge clk);
    if (rstn && prev_txd && !txd) begin
      rx_starts++;
      rx_ab = 1'b0;
      repeat (H) begin @(negedge clk); if (!rstn) rx_ab = 1'b1; end
      rx_st = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (BITC) begin @(negedge clk); if (!rstn) rx_ab = 1'b1; end
        rx_b[i] = txd;
      end
      repeat (BITC) begin @(negedge clk); if (!rstn) rx_ab = 1'b1; end
      rx_sp = txd;
      if (!rx_ab) begin
        check("rx_start_bit", rx_st, 0);
        check("rx_stop_bit", rx_sp, 1);
        check("rx_sb_avail", sb.size() > 0, 1);
        if (sb.size() > 0) check("rx_byte", rx_b, sb.pop_front());
      end
    end
    prev_txd = txd;
  end

  task automatic wr(input logic [7:0] b);
    @(negedge clk); we = 1'b1; wdata = b;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic wait_fall(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check(tag, txd, 0);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    @(negedge clk);
    while (idle !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
    check(tag, idle, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, errs, peak, to;
    logic exp_b;

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_idle", idle, 1);
    check("rst_ovf", ovf, 0);
    check("rst_txd", txd, 1);

    // Single byte 0x55: latency, exact waveform, one start pulse
    p0 = pulses;
    sb.push_back(8'h55);
    @(negedge clk); we = 1'b1; wdata = 8'h55;
    @(negedge clk); we = 1'b0;
    check("wr_count", count, 1);
    check("wr_empty", empty, 0);
    check("wr_idle", idle, 0);
    @(negedge clk);
    check("pop_count", count, 0);
    check("pop_tx_start", dut.r_tx_start, 1);
    @(negedge clk);
    errs = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      exp_b = ((k / BITC) % 2) == 1;
      if (txd !== exp_b) errs++;
    end
    check("frame_55_wave", errs, 0);
    check("tx_start_pulses", pulses - p0, 1);
    wait_idle("idle_after_55", 200);
    check("txd_after_55", txd, 1);

    // Ordering with three back-to-back writes
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h03);
    peak = 0;
    @(negedge clk); we = 1'b1; wdata = 8'h01;
    @(negedge clk); wdata = 8'h02; if (count > peak) peak = count;
    @(negedge clk); wdata = 8'h03; if (count > peak) peak = count;
    @(negedge clk); we = 1'b0;     if (count > peak) peak = count;
    @(negedge clk);                if (count > peak) peak = count;
    check("order_peak", peak, 2);
    wait_idle("idle_order", 600);
    check("order_count_end", count, 0);

    // Overflow while the serialiser is busy
    sb.push_back(8'hEE);
    wr(8'hEE);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) check("full_before_4th", full, 0);
      if (i == 4) begin
        check("full_after_4th", full, 1);
        check("count_after_4th", count, 4);
      end
      we = 1'b1; wdata = 8'hA0 + 8'(i);
      if (i < 4) sb.push_back(8'hA0 + 8'(i));
    end
    @(negedge clk); we = 1'b0;
    check("ovf_count", count, 4);
    check("ovf_full", full, 1);
    check("ovf_flag", ovf, c_ovf_exp);
    wait_idle("idle_ovf", 800);
    check("ovf_sticky", ovf, c_ovf_exp);
    check("ovf_empty_end", empty, 1);

    // Wrap-around: 10 bytes paced on !full
    to = 0;
    for (int b = 8'h10; b <= 8'h19; b++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (full && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) to++;
      we = 1'b1; wdata = 8'(b); sb.push_back(8'(b));
      @(negedge clk); we = 1'b0;
    end
    check("wrap_no_stall", to, 0);
    wait_idle("idle_wrap", 1500);

    // Write in the exact cycle of a pop with count==2
    sb.push_back(8'h31);
    wr(8'h31);
    wait_fall("simul_frame_start");
    @(negedge clk); we = 1'b1; wdata = 8'h32; sb.push_back(8'h32);
    @(negedge clk); wdata = 8'h33; sb.push_back(8'h33);
    @(negedge clk); we = 1'b0;
    repeat (FRAME + 1 - 3) @(negedge clk);
    check("simul_pre_count", count, 2);
    we = 1'b1; wdata = 8'h34; sb.push_back(8'h34);
    @(negedge clk); we = 1'b0;
    check("simul_count", count, 2);
    check("simul_popped", dut.r_tx_start, 1);
    wait_idle("idle_simul", 800);

    // Reset during data bit 3 of 0xFF with two bytes queued
    wr(8'hFF);
    wait_fall("rst_frame_start");
    @(negedge clk); we = 1'b1; wdata = 8'h11;
    @(negedge clk); wdata = 8'h22;
    @(negedge clk); we = 1'b0;
    repeat (9 * H - 3) @(negedge clk);
    check("rst_mid_count_before", count, 2);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid_txd", txd, 1);
    check("rst_mid_count", count, 0);
    check("rst_mid_ovf", ovf, 0);
    check("rst_mid_empty", empty, 1);
    @(negedge clk);
    rstn = 1'b1;
    s0 = rx_starts;
    p0 = pulses;
    repeat (300) @(negedge clk);
    check("rst_no_frames", rx_starts - s0, 0);
    check("rst_no_starts", pulses - p0, 0);
    check("rst_idle_end", idle, 1);
    check("rst_txd_end", txd, 1);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
